frame_binarizer: RTL
====================

// Module: frame_binarizer
// PURPOSE
//  Upstream feeder for the digit classifier. Captures a 280x280 8-bit grayscale pixel
//  stream and reduces it to a 28x28 binary image: one bit per SCALExSCALE block, set
//  when the block holds enough ink. The result is served on the classifier's bit-serial
//  read port (read_addr -> read_data).
//  Double-buffered: the classifier only ever sees complete frames.
// PARAMETERS
//  IMG_SIDE   28   output image side in bits (784 bits total)
//  SCALE      10   input pixels per output bit, each axis; input side = IMG_SIDE*SCALE
//  PIX_W      8    grayscale pixel width
//  INK_LEVEL  128  a pixel is ink when pix_data >= INK_LEVEL (unsigned)
//  THRESHOLD  30   block bit = 1 when ink count >= THRESHOLD (range 1..SCALE*SCALE)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      asynchronous, active-high reset
//  pix_valid    in   1      pix_data/pix_sof valid this cycle
//  pix_sof      in   1      qualifies pix_valid: pixel (0,0) of a new frame
//  pix_data     in   PIX_W  grayscale value, raster order, row 0 first
//  read_addr    in   10     bit index = row*IMG_SIDE + col
//  read_data    out  1      front_buf[read_addr]; 0 when read_addr >= IMG_SIDE^2
//  frame_done   out  1      one-cycle pulse after a new frame becomes visible
//  frame_count  out  8      completed frames, wraps 255 -> 0
//  busy         out  1      1 while in CAPTURE
// BEHAVIOUR
//  Reset: state=IDLE; front_buf, back_buf, ink counters, x/y sub-counters = 0;
//   frame_done=0, frame_count=0, busy=0; read_data therefore 0.
//  Storage: front_buf[783:0] is read, back_buf[783:0] is written.
//   cnt[0..IMG_SIDE-1]: one ink counter per block column, width clog2(SCALE*SCALE+1)=7.
//  Position: xsub (0..SCALE-1), bx (0..IMG_SIDE-1), ysub, by. No dividers are used.
//  An accepted pixel advances xsub/bx; row end (bx=IMG_SIDE-1, xsub=SCALE-1) wraps them
//   and advances ysub/by.
//  FSM IDLE:
//   - pix_valid&&pix_sof: go to CAPTURE, clear all cnt, set position to (0,0), then
//     accept this pixel.
//   - Every other pixel is dropped.
//  FSM CAPTURE:
//   - Each pix_valid pixel: cnt[bx] += (pix_data>=INK_LEVEL).
//   - pix_valid&&pix_sof mid-frame: abort and restart as in IDLE. back_buf is kept but
//     will be overwritten. No swap, no frame_done.
//  Row commit, on the pixel with bx=IMG_SIDE-1, xsub=SCALE-1, ysub=SCALE-1 (same cycle):
//   - Each bit back_buf[by*IMG_SIDE+i] = (cnt_next[i] >= THRESHOLD), where cnt_next
//     includes the current pixel.
//   - All cnt are cleared to 0.
//  Frame end = row commit with by=IMG_SIDE-1. In that same cycle:
//   - front_buf <= back_buf with the last row replaced by the newly committed bits.
//   - State -> IDLE.
//   Next cycle: frame_done=1 for exactly one cycle, frame_count+1, busy=0.
//  read_data is combinational from read_addr and front_buf; it changes only at a swap.
//  Pixels after frame end and before the next sof are dropped.
//  pix_valid=0 stalls without limit; gaps have no effect on the result.
//  Mid-operation rst: everything returns to reset values, front_buf included.
// TESTING
//  1. rst; one all-0xFF frame (78400 pixels with sof on the first)
//     -> frame_done 1 cycle after the last pixel; all 784 read_data=1; frame_count=1.
//  2. All-0x00 frame after test 1 -> every bit 0; during capture read_data stays all 1
//     (double buffer), frame_count=2.
//  3. Block (3,5) has exactly 30 ink pixels, block (3,6) has 29, rest 0 -> bit 89=1,
//     bit 90=0, all other bits 0.
//  4. sof reasserted at pixel 40000 of a frame, then a full frame -> exactly one
//     frame_done; the result matches the second frame only.
//  5. Random pix_valid gaps (about 50% duty) on the test-3 frame -> identical bits.
//     read_addr=784..1023 -> read_data=0.
//  6. rst asserted mid-capture after test 1 -> read_data=0 at all addresses,
//     frame_count=0, busy=0. Non-sof pixels are dropped until the next sof.

Source files
------------

// File: rtl/frame_binarizer.sv
// frame_binarizer: reduces a raster grayscale stream of (IMG_SIDE*SCALE)^2 pixels
// to an IMG_SIDE x IMG_SIDE binary image. Each output bit is set when its
// SCALE x SCALE block holds at least THRESHOLD ink pixels. A double buffer
// makes sure the reader only ever sees complete frames.
module frame_binarizer #(
   parameter int IMG_SIDE  = 28,
   parameter int SCALE     = 10,
   parameter int PIX_W     = 8,
   parameter int INK_LEVEL = 128,
   parameter int THRESHOLD = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pix_valid,
   input  logic             pix_sof,
   input  logic [PIX_W-1:0] pix_data,
   input  logic [9:0]       read_addr,
   output logic             read_data,
   output logic             frame_done,
   output logic [7:0]       frame_count,
   output logic             busy
);

   localparam int NBITS  = IMG_SIDE * IMG_SIDE;
   localparam int ADDR_W = 10;
   localparam int CNT_W  = $clog2(SCALE * SCALE + 1);
   localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam int BLK_W  = (IMG_SIDE > 1) ? $clog2(IMG_SIDE) : 1;

   localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(IMG_SIDE - 1);
   localparam logic [PIX_W-1:0]  INK      = PIX_W'(INK_LEVEL);
   localparam logic [CNT_W-1:0]  THR      = CNT_W'(THRESHOLD);

   typedef enum logic {
      ST_IDLE,
      ST_CAPTURE
   } state_t;

   state_t r_state, w_state_next;

   logic [NBITS-1:0] r_front, r_back;
   logic [CNT_W-1:0] r_cnt [IMG_SIDE];
   logic [SUB_W-1:0] r_xsub, r_ysub;
   logic [BLK_W-1:0] r_bx, r_by;
   logic             r_frame_done;
   logic [7:0]       r_frame_count;

   logic             w_start, w_accept, w_ink, w_row_end, w_commit, w_frame_end;
   logic [SUB_W-1:0] w_xsub, w_ysub, w_xsub_n, w_ysub_n;
   logic [BLK_W-1:0] w_bx, w_by, w_bx_n, w_by_n;
   logic [CNT_W-1:0] w_cnt_next [IMG_SIDE];
   logic [IMG_SIDE-1:0] w_row_bits;
   logic [ADDR_W-1:0]   w_row_base;
   logic [NBITS-1:0]    w_front_next;
   logic                w_addr_ok;

   // Datapath: effective position (a sof restarts at block 0,0), ink accumulation,
   // row commit bits and the image that becomes visible at frame end.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_start   = pix_valid && pix_sof;
      w_accept  = pix_valid && (w_start || (r_state == ST_CAPTURE));
      w_xsub    = w_start ? '0 : r_xsub;
      w_ysub    = w_start ? '0 : r_ysub;
      w_bx      = w_start ? '0 : r_bx;
      w_by      = w_start ? '0 : r_by;
      w_ink     = (pix_data >= INK);
      w_row_end = (w_xsub == SUB_LAST) && (w_bx == BLK_LAST);
      w_commit  = w_accept && w_row_end && (w_ysub == SUB_LAST);
      w_frame_end = w_commit && (w_by == BLK_LAST);

      w_xsub_n = (w_xsub == SUB_LAST) ? '0 : SUB_W'(w_xsub + 1'b1);
      w_bx_n   = w_bx;
      w_ysub_n = w_ysub;
      w_by_n   = w_by;
      if (w_xsub == SUB_LAST) begin
         w_bx_n = (w_bx == BLK_LAST) ? '0 : BLK_W'(w_bx + 1'b1);
      end
      if (w_row_end) begin
         w_ysub_n = (w_ysub == SUB_LAST) ? '0 : SUB_W'(w_ysub + 1'b1);
         if (w_ysub == SUB_LAST) begin
            w_by_n = (w_by == BLK_LAST) ? '0 : BLK_W'(w_by + 1'b1);
         end
      end

      for (int i = 0; i < IMG_SIDE; i++) begin
         w_cnt_next[i] = (w_start ? '0 : r_cnt[i])
                       + CNT_W'(w_accept && w_ink && (w_bx == BLK_W'(i)));
         w_row_bits[i] = (w_cnt_next[i] >= THR);
      end

      w_row_base   = ADDR_W'(w_by) * ADDR_W'(IMG_SIDE);
      w_front_next = r_back;
      w_front_next[NBITS-IMG_SIDE +: IMG_SIDE] = w_row_bits;

      w_addr_ok = (read_addr < ADDR_W'(NBITS));
      read_data = w_addr_ok ? r_front[read_addr] : 1'b0;
   end

   // Next-state: a sof (re)starts capture, the last row commit returns to idle.
   always_comb begin
      w_state_next = r_state;
      if (w_frame_end) begin
         w_state_next = ST_IDLE;
      end else if (w_start) begin
         w_state_next = ST_CAPTURE;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Counters, position, buffers and frame status.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: both image buffers are cleared by reset, so they must stay flops rather than RAM.
      if (rst) begin
         r_front       <= '0;
         r_back        <= '0;
         r_xsub        <= '0;
         r_ysub        <= '0;
         r_bx          <= '0;
         r_by          <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         for (int i = 0; i < IMG_SIDE; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_frame_done <= w_frame_end;
         if (w_frame_end) begin
            r_frame_count <= r_frame_count + 8'd1;
            r_front       <= w_front_next;
         end
         if (w_accept) begin
            r_xsub <= w_xsub_n;
            r_ysub <= w_ysub_n;
            r_bx   <= w_bx_n;
            r_by   <= w_by_n;
            for (int i = 0; i < IMG_SIDE; i++) begin
               r_cnt[i] <= w_commit ? '0 : w_cnt_next[i];
            end
         end
         if (w_commit) begin
            r_back[w_row_base +: IMG_SIDE] <= w_row_bits;
         end
      end
   end

   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign busy        = (r_state == ST_CAPTURE);

endmodule
